// File: rtl/rs_station.sv
// Reservation station: compacting age-ordered queue of ALU micro-ops with
// multi-port CDB wakeup, oldest-ready select and a registered dispatch stage.
module rs_station #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int NUM_BC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [OP_W-1:0]            issue_op,
    input  logic [DATA_W-1:0]          issue_vj,
    input  logic [DATA_W-1:0]          issue_vk,
    input  logic                       issue_pj,
    input  logic                       issue_pk,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic [TAG_W-1:0]           issue_qk,
    input  logic [DATA_W-1:0]          issue_imm,
    input  logic [DATA_W-1:0]          issue_pc,
    input  logic [TAG_W-1:0]           issue_tag,
    input  logic [NUM_BC-1:0]          bc_valid,
    input  logic [NUM_BC*TAG_W-1:0]    bc_tag,
    input  logic [NUM_BC*DATA_W-1:0]   bc_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_op,
    output logic [DATA_W-1:0]          out_vj,
    output logic [DATA_W-1:0]          out_vk,
    output logic [DATA_W-1:0]          out_imm,
    output logic [DATA_W-1:0]          out_pc,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OP_W-1:0]   op_q  [DEPTH], op_d  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH], vj_d  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH], vk_d  [DEPTH];
    logic              pj_q  [DEPTH], pj_d  [DEPTH];
    logic              pk_q  [DEPTH], pk_d  [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH], qj_d  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH], qk_d  [DEPTH];
    logic [DATA_W-1:0] imm_q [DEPTH], imm_d [DEPTH];
    logic [DATA_W-1:0] pc_q  [DEPTH], pc_d  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH], tag_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;

    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [DATA_W-1:0] out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic [DATA_W-1:0] w_vj [DEPTH], w_vk [DEPTH];
    logic              w_pj [DEPTH], w_pk [DEPTH];
    logic [DATA_W-1:0] n_vj, n_vk;
    logic              n_pj, n_pk;
    logic [DEPTH-1:0]  shift;
    logic              found;
    logic [IW-1:0]     sel, src;
    logic [CW-1:0]     alloc_idx;
    logic              disp_en, do_disp, do_alloc;

    assign issue_ready = (count_q != CW'(DEPTH));

    // Wakeup of held entries and same-cycle bypass for the incoming op.
    // Ports are scanned high to low so the lowest matching port wins.
    always_comb begin
        n_vj = issue_vj;
        n_pj = issue_pj;
        n_vk = issue_vk;
        n_pk = issue_pk;
        for (int i = 0; i < DEPTH; i++) begin
            w_vj[i] = vj_q[i];
            w_pj[i] = pj_q[i];
            w_vk[i] = vk_q[i];
            w_pk[i] = pk_q[i];
        end
        for (int k = NUM_BC - 1; k >= 0; k--) begin
            if (bc_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (pj_q[i] && bc_tag[k*TAG_W +: TAG_W] == qj_q[i]) begin
                        w_vj[i] = bc_value[k*DATA_W +: DATA_W];
                        w_pj[i] = 1'b0;
                    end
                    if (pk_q[i] && bc_tag[k*TAG_W +: TAG_W] == qk_q[i]) begin
                        w_vk[i] = bc_value[k*DATA_W +: DATA_W];
                        w_pk[i] = 1'b0;
                    end
                end
                if (issue_pj && bc_tag[k*TAG_W +: TAG_W] == issue_qj) begin
                    n_vj = bc_value[k*DATA_W +: DATA_W];
                    n_pj = 1'b0;
                end
                if (issue_pk && bc_tag[k*TAG_W +: TAG_W] == issue_qk) begin
                    n_vk = bc_value[k*DATA_W +: DATA_W];
                    n_pk = 1'b0;
                end
            end
        end
    end

    // shift[i] marks slots at or above the selected one; they move down on dispatch.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && (CW'(i) < count_q) && !pj_q[i] && !pk_q[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
            shift[i] = found;
        end
    end

    always_comb begin
        disp_en   = !out_valid_q || out_ready;
        do_disp   = disp_en && found && !flush;
        do_alloc  = issue_valid && issue_ready && !flush;
        alloc_idx = count_q - CW'(do_disp);
        src       = '0;

        for (int i = 0; i < DEPTH; i++) begin
            src = IW'(i);
            if (do_disp && shift[i] && (i < DEPTH - 1)) begin
                src = IW'(i + 1);
            end
            op_d[i]  = op_q[src];
            vj_d[i]  = w_vj[src];
            vk_d[i]  = w_vk[src];
            pj_d[i]  = w_pj[src];
            pk_d[i]  = w_pk[src];
            qj_d[i]  = qj_q[src];
            qk_d[i]  = qk_q[src];
            imm_d[i] = imm_q[src];
            pc_d[i]  = pc_q[src];
            tag_d[i] = tag_q[src];
            if (do_alloc && alloc_idx == CW'(i)) begin
                op_d[i]  = issue_op;
                vj_d[i]  = n_vj;
                vk_d[i]  = n_vk;
                pj_d[i]  = n_pj;
                pk_d[i]  = n_pk;
                qj_d[i]  = issue_qj;
                qk_d[i]  = issue_qk;
                imm_d[i] = issue_imm;
                pc_d[i]  = issue_pc;
                tag_d[i] = issue_tag;
            end
        end

        count_d = count_q + CW'(do_alloc) - CW'(do_disp);
        if (flush) begin
            count_d = '0;
        end

        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (do_disp) begin
            out_valid_d = 1'b1;
            out_op_d    = op_q[sel];
            out_vj_d    = vj_q[sel];
            out_vk_d    = vk_q[sel];
            out_imm_d   = imm_q[sel];
            out_pc_d    = pc_q[sel];
            out_tag_d   = tag_q[sel];
        end else if (disp_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                pj_q[i]  <= 1'b0;
                pk_q[i]  <= 1'b0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                tag_q[i] <= '0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= op_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
                pj_q[i]  <= pj_d[i];
                pk_q[i]  <= pk_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
                imm_q[i] <= imm_d[i];
                pc_q[i]  <= pc_d[i];
                tag_q[i] <= tag_d[i];
            end
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_vj    = out_vj_q;
    assign out_vk    = out_vk_q;
    assign out_imm   = out_imm_q;
    assign out_pc    = out_pc_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: expected dispatches queued at stimulus time and
// popped by a monitor on every output handshake; scenario tasks check timing.
module tb_rs_station;
    logic        clk, rst, flush;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_op;
    logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
    logic        issue_pj, issue_pk;
    logic [3:0]  issue_qj, issue_qk, issue_tag;
    logic [1:0]  bc_valid;
    logic [7:0]  bc_tag;
    logic [63:0] bc_value;
    logic        out_valid, out_ready;
    logic [5:0]  out_op;
    logic [31:0] out_vj, out_vk, out_imm, out_pc;
    logic [3:0]  out_tag;
    logic [3:0]  count;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    rs_station #(.DEPTH(8), .TAG_W(4), .DATA_W(32), .OP_W(6), .NUM_BC(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_pj(issue_pj), .issue_pk(issue_pk),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_tag(issue_tag),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_value(bc_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_vj(out_vj), .out_vk(out_vk),
        .out_imm(out_imm), .out_pc(out_pc), .out_tag(out_tag),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imm_of(input logic [3:0] t);
        return 32'h100 + {28'h0, t};
    endfunction

    function automatic logic [31:0] pc_of(input logic [3:0] t);
        return 32'h1000 + {26'h0, t, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic pj, input logic pk, input logic [3:0] qj,
                             input logic [3:0] qk, input logic [3:0] tag);
        issue_valid = 1'b1;
        issue_op  = op;
        issue_vj  = vj;
        issue_vk  = vk;
        issue_pj  = pj;
        issue_pk  = pk;
        issue_qj  = qj;
        issue_qk  = qk;
        issue_tag = tag;
        issue_imm = imm_of(tag);
        issue_pc  = pc_of(tag);
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [3:0] tag);
        exp_t e;
        e.op  = op;
        e.vj  = vj;
        e.vk  = vk;
        e.imm = imm_of(tag);
        e.pc  = pc_of(tag);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Scoreboard: a handshake at the coming edge must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && !flush && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: dispatched tag=%0d, required no dispatch", out_tag);
            end else begin
                mon_e = sb.pop_front();
                if (out_tag !== mon_e.tag || out_op !== mon_e.op || out_vj !== mon_e.vj ||
                    out_vk !== mon_e.vk || out_imm !== mon_e.imm || out_pc !== mon_e.pc) begin
                    n_fail++;
                    $display("FAIL sb_dispatch: got tag=%0d op=%0d vj=%h vk=%h imm=%h pc=%h, required tag=%0d op=%0d vj=%h vk=%h imm=%h pc=%h",
                             out_tag, out_op, out_vj, out_vk, out_imm, out_pc,
                             mon_e.tag, mon_e.op, mon_e.vj, mon_e.vk, mon_e.imm, mon_e.pc);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        n_tests++;
        if (count !== 4'd0 || out_valid !== 1'b0 || issue_ready !== 1'b1 ||
            out_tag !== 4'd0 || out_vj !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d out_valid=%b issue_ready=%b out_tag=%0d out_vj=%h, required 0 0 1 0 0",
                     count, out_valid, issue_ready, out_tag, out_vj);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_issue(6'd3, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
        push_exp(6'd3, 32'd5, 32'd7, 4'd2);
        tick();
        issue_valid = 1'b0;
        n_tests++;
        if (count !== 4'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_t: count=%0d out_valid=%b, required 1 0", count, out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_vj !== 32'd5 || out_vk !== 32'd7 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_t1: out_valid=%b tag=%0d vj=%0d vk=%0d count=%0d, required 1 2 5 7 0",
                     out_valid, out_tag, out_vj, out_vk, count);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_wakeup();
        out_ready = 1'b1;
        set_issue(6'd1, 32'd0, 32'd3, 1'b1, 1'b0, 4'd9, 4'd0, 4'd1);
        tick();
        set_issue(6'd2, 32'd4, 32'd5, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
        push_exp(6'd2, 32'd4, 32'd5, 4'd2);
        tick();
        issue_valid = 1'b0;
        bc_valid = 2'b10;
        bc_tag   = {4'd9, 4'd0};
        bc_value = {32'hAB, 32'h0};
        push_exp(6'd1, 32'hAB, 32'd3, 4'd1);
        tick();
        bc_valid = 2'b00;
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd2 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL wakeup_first: out_valid=%b tag=%0d count=%0d, required 1 2 1", out_valid, out_tag, count);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_vj !== 32'hAB || count !== 4'd0) begin
            n_fail++;
            $display("FAIL wakeup_second: out_valid=%b tag=%0d vj=%h count=%0d, required 1 1 ab 0",
                     out_valid, out_tag, out_vj, count);
        end
        tick();
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_issue(6'(i + 10), 32'd0, 32'(i), 1'b1, 1'b0, 4'd4, 4'd0, 4'(i));
            tick();
        end
        set_issue(6'd63, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15);
        n_tests++;
        if (count !== 4'd8 || issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: count=%0d issue_ready=%b, required 8 0", count, issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        n_tests++;
        if (count !== 4'd8 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_reject: count=%0d out_valid=%b, required 8 0", count, out_valid);
        end
        bc_valid = 2'b01;
        bc_tag   = {4'd0, 4'd4};
        bc_value = {32'h0, 32'h44};
        for (int i = 0; i < 8; i++) push_exp(6'(i + 10), 32'h44, 32'(i), 4'(i));
        tick();
        bc_valid = 2'b00;
        n_tests++;
        if (count !== 4'd8 || issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dispatch_ready: count=%0d issue_ready=%b, required 8 0", count, issue_ready);
        end
        tick();
        n_tests++;
        if (count !== 4'd7 || out_valid !== 1'b1 || out_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL full_first: count=%0d out_valid=%b tag=%0d, required 7 1 0", count, out_valid, out_tag);
        end
        tick();
        n_tests++;
        if (count !== 4'd6 || out_tag !== 4'd1) begin
            n_fail++;
            $display("FAIL full_second: count=%0d tag=%0d, required 6 1", count, out_tag);
        end
        for (int n = 0; n < 30; n++) begin
            if (sb.size() == 0 && out_valid == 1'b0) break;
            tick();
        end
        n_tests++;
        if (sb.size() != 0 || out_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drain: pending=%0d out_valid=%b count=%0d, required 0 0 0", sb.size(), out_valid, count);
        end
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        set_issue(6'd7, 32'd1, 32'd0, 1'b0, 1'b1, 4'd0, 4'd6, 4'd5);
        bc_valid = 2'b10;
        bc_tag   = {4'd6, 4'd0};
        bc_value = {32'h10, 32'h0};
        push_exp(6'd7, 32'd1, 32'h10, 4'd5);
        tick();
        issue_valid = 1'b0;
        bc_valid = 2'b00;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd5 || out_vk !== 32'h10 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL bypass: out_valid=%b tag=%0d vk=%h count=%0d, required 1 5 10 0", out_valid, out_tag, out_vk, count);
        end
        set_issue(6'd8, 32'd0, 32'd2, 1'b1, 1'b0, 4'd7, 4'd0, 4'd6);
        tick();
        issue_valid = 1'b0;
        bc_valid = 2'b11;
        bc_tag   = {4'd7, 4'd7};
        bc_value = {32'h71, 32'h70};
        push_exp(6'd8, 32'h70, 32'd2, 4'd6);
        tick();
        bc_valid = 2'b00;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd6 || out_vj !== 32'h70) begin
            n_fail++;
            $display("FAIL port_priority: out_valid=%b tag=%0d vj=%h, required 1 6 70", out_valid, out_tag, out_vj);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_issue(6'd20, 32'd21, 32'd22, 1'b0, 1'b0, 4'd0, 4'd0, 4'd8);
        push_exp(6'd20, 32'd21, 32'd22, 4'd8);
        tick();
        set_issue(6'd30, 32'd31, 32'd32, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9);
        push_exp(6'd30, 32'd31, 32'd32, 4'd9);
        tick();
        issue_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_tag !== 4'd8 || out_vj !== 32'd21 || count !== 4'd1) begin
                n_fail++;
                $display("FAIL hold_%0d: out_valid=%b tag=%0d vj=%0d count=%0d, required 1 8 21 1",
                         n, out_valid, out_tag, out_vj, count);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd9 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_release: out_valid=%b tag=%0d count=%0d, required 1 9 0", out_valid, out_tag, count);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_issue(6'd40, 32'(i), 32'(i), 1'b0, 1'b0, 4'd0, 4'd0, 4'(i));
            tick();
        end
        n_tests++;
        if (count !== 4'd5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: count=%0d out_valid=%b, required 5 1", count, out_valid);
        end
        set_issue(6'd41, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        n_tests++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: count=%0d out_valid=%b, required 0 0", count, out_valid);
        end
        tick();
        n_tests++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_noalloc: count=%0d out_valid=%b, required 0 0", count, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_issue(6'd50, 32'd51, 32'd52, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        tick();
        set_issue(6'd53, 32'd54, 32'd55, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4);
        tick();
        issue_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd3 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL areset_pre: out_valid=%b tag=%0d count=%0d, required 1 3 1", out_valid, out_tag, count);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 4'd0 || issue_ready !== 1'b1 || out_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_now: out_valid=%b count=%0d issue_ready=%b tag=%0d, required 0 0 1 0",
                     out_valid, count, issue_ready, out_tag);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        set_issue(6'd60, 32'd61, 32'd62, 1'b0, 1'b0, 4'd0, 4'd0, 4'd10);
        push_exp(6'd60, 32'd61, 32'd62, 4'd10);
        tick();
        issue_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 4'd10 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_resume: out_valid=%b tag=%0d count=%0d, required 1 10 0", out_valid, out_tag, count);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_op = '0; issue_vj = '0; issue_vk = '0; issue_pj = 1'b0; issue_pk = 1'b0;
        issue_qj = '0; issue_qk = '0; issue_imm = '0; issue_pc = '0; issue_tag = '0;
        bc_valid = '0; bc_tag = '0; bc_value = '0;
        out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_bypass();
        test_backpressure();
        test_flush();
        test_async_reset();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected dispatches never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
